pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Tracks in-flight register writers in a 3-entry scoreboard covering EX, MEM and WB.
- Stalls ID on RAW hazards against decoded rs1/rs2.
- Kills the ID instruction on an EX-resolved branch or jump redirect.
- Freezes the whole pipeline while data memory is busy.
- Counts stall and flush cycles for performance monitoring.

Parameters:
- REG_ADDR_W, 5: register index width.
- CNT_W, 32: width of the performance counters.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_id_valid  in  1  ID holds a real instruction.
- i_id_rs1  in  REG_ADDR_W  rs1 index of the ID instruction.
- i_id_rs2  in  REG_ADDR_W  rs2 index of the ID instruction.
- i_id_uses_rs1  in  1  ID instruction reads rs1.
- i_id_uses_rs2  in  1  ID instruction reads rs2.
- i_id_rd  in  REG_ADDR_W  rd index of the ID instruction.
- i_id_is_reg_write  in  1  ID instruction writes rd.
- i_id_is_load  in  1  ID instruction is a load.
- i_ex_redirect  in  1  branch taken or jump in EX this cycle.
- i_mem_busy  in  1  data memory not ready; pipeline must freeze.
- o_stall_if  out  1  hold PC and IF/ID register.
- o_stall_id  out  1  hold ID.
- o_stall_ex  out  1  hold EX/MEM/WB registers (memory freeze).
- o_bubble_ex  out  1  load a NOP into ID/EX.
- o_flush_if_id  out  1  clear the IF/ID register.
- o_stall_count  out  CNT_W  cycles with any stall asserted.
- o_flush_count  out  CNT_W  redirect cycles honoured.

Behaviour:
- Scoreboard entries sb_ex, sb_mem, sb_wb each hold {v, rd, ld}. On reset all v=0 and both counters are 0.
- match(e, rs) = e.v && e.rd != 0 && e.rd == rs. Evaluate against rs1 when uses_rs1 and against rs2 when uses_rs2.
- The register file has no write-through: a WB match is still a hazard.
- raw = i_id_valid && (match against any of sb_ex, sb_mem, sb_wb).
- Priority, highest first:
  - memfreeze = i_mem_busy. Drives o_stall_if = o_stall_id = o_stall_ex = 1 and o_bubble_ex = 0. The scoreboard holds. Redirect and raw are ignored this cycle; EX is frozen, so i_ex_redirect stays asserted and is honoured on the first non-busy cycle.
  - redirect = i_ex_redirect && !i_mem_busy. Drives o_flush_if_id = 1 and o_bubble_ex = 1, all stalls 0. raw is ignored because the ID instruction is dead.
  - hazard = raw && !i_mem_busy && !i_ex_redirect. Drives o_stall_if = o_stall_id = 1, o_bubble_ex = 1, o_stall_ex = 0.
- All control outputs are combinational from scoreboard state and inputs: zero-cycle latency.
- Scoreboard update on each clock edge when !i_mem_busy:
  - sb_wb <= sb_mem; sb_mem <= sb_ex.
  - sb_ex <= {i_id_valid && i_id_is_reg_write, i_id_rd, i_id_is_load} when neither redirect nor hazard is active; otherwise sb_ex <= invalid (the bubble).
- Counters:
  - o_stall_count increments when any of o_stall_if, o_stall_id, o_stall_ex is 1.
  - o_flush_count increments when redirect is active.
  - Both wrap modulo 2^CNT_W.
- Reset mid-stall: the cycle after i_rst, all outputs are 0 and the scoreboard is empty.
- Reset has priority over every input.

Optional Feature:
FORWARDING_EN.
- When defined, add outputs o_fwd_rs1_sel and o_fwd_rs2_sel (2 bits each). The encoding is:
  - 0: register file.
  - 1: EX result.
  - 2: MEM result.
  - 3: WB result.
- Selection rule: the youngest matching entry wins (EX > MEM > WB).
- raw is redefined as a match against a load entry in sb_ex or sb_mem only; load data exists only at WB.
- Non-load matches and WB-load matches forward without stalling.
- Without FORWARDING_EN these ports are absent and raw uses all three entries as above.

Test Plan:
- add x5 then dependent add x6,x5,x1; no FORWARDING_EN -> o_stall_id high exactly 3 cycles with o_bubble_ex each cycle; consumer issues on cycle 4; o_stall_count = 3.
- Same sequence with FORWARDING_EN -> no stall; o_fwd_rs1_sel = 1 at issue.
- lw x5 then dependent add, FORWARDING_EN -> 2 stall cycles, then o_fwd_rs1_sel = 3.
- Producer with rd = x0 followed by a reader of x0 -> no stall, sel = 0.
- i_ex_redirect together with a raw hazard -> o_flush_if_id = 1, o_bubble_ex = 1, o_stall_id = 0; o_flush_count increments by 1.
- i_mem_busy held 4 cycles with i_ex_redirect asserted, i_rst pulsed on the next cycle -> 4 freeze cycles with the scoreboard unchanged and no flush counted; after reset all outputs and counters are 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: RAW scoreboard, redirect kill, memory freeze, perf counters.
// Define FORWARDING_EN to add forwarding-select outputs and restrict stalls to load-use hazards.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_is_reg_write,
    input  logic                  i_id_is_load,
    input  logic                  i_ex_redirect,
    input  logic                  i_mem_busy,
    output logic                  o_stall_if,
    output logic                  o_stall_id,
    output logic                  o_stall_ex,
    output logic                  o_bubble_ex,
    output logic                  o_flush_if_id,
`ifdef FORWARDING_EN
    output logic [1:0]            o_fwd_rs1_sel,
    output logic [1:0]            o_fwd_rs2_sel,
`endif
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_flush_count
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  ld;
    } sb_entry_t;

    sb_entry_t sb_ex, sb_mem, sb_wb;

    logic m1_ex, m1_mem, m1_wb;
    logic m2_ex, m2_mem, m2_wb;
    logic raw_src, raw;
    logic memfreeze, redirect, hazard;

    function automatic logic hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] rs);
        return e.v && (e.rd != '0) && (e.rd == rs);
    endfunction

    always_comb begin
        m1_ex  = i_id_uses_rs1 && hit(sb_ex,  i_id_rs1);
        m1_mem = i_id_uses_rs1 && hit(sb_mem, i_id_rs1);
        m1_wb  = i_id_uses_rs1 && hit(sb_wb,  i_id_rs1);
        m2_ex  = i_id_uses_rs2 && hit(sb_ex,  i_id_rs2);
        m2_mem = i_id_uses_rs2 && hit(sb_mem, i_id_rs2);
        m2_wb  = i_id_uses_rs2 && hit(sb_wb,  i_id_rs2);
    end

`ifdef FORWARDING_EN
    // Load data only becomes available at WB, so only EX/MEM load matches stall.
    assign raw_src = ((m1_ex || m2_ex) && sb_ex.ld) || ((m1_mem || m2_mem) && sb_mem.ld);

    always_comb begin
        o_fwd_rs1_sel = 2'd0;
        if (m1_ex)       o_fwd_rs1_sel = 2'd1;
        else if (m1_mem) o_fwd_rs1_sel = 2'd2;
        else if (m1_wb)  o_fwd_rs1_sel = 2'd3;
        o_fwd_rs2_sel = 2'd0;
        if (m2_ex)       o_fwd_rs2_sel = 2'd1;
        else if (m2_mem) o_fwd_rs2_sel = 2'd2;
        else if (m2_wb)  o_fwd_rs2_sel = 2'd3;
    end

    logic unused_ld;
    assign unused_ld = sb_wb.ld;
`else
    assign raw_src = m1_ex || m1_mem || m1_wb || m2_ex || m2_mem || m2_wb;

    logic unused_ld;
    assign unused_ld = ^{sb_ex.ld, sb_mem.ld, sb_wb.ld};
`endif

    assign raw       = i_id_valid && raw_src;
    assign memfreeze = i_mem_busy;
    assign redirect  = i_ex_redirect && !i_mem_busy;
    assign hazard    = raw && !i_mem_busy && !i_ex_redirect;

    assign o_stall_if    = memfreeze || hazard;
    assign o_stall_id    = memfreeze || hazard;
    assign o_stall_ex    = memfreeze;
    assign o_bubble_ex   = redirect || hazard;
    assign o_flush_if_id = redirect;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sb_ex         <= '0;
            sb_mem        <= '0;
            sb_wb         <= '0;
            o_stall_count <= '0;
            o_flush_count <= '0;
        end else begin
            // A busy memory freezes EX/MEM/WB, so the scoreboard must not advance.
            if (!i_mem_busy) begin
                sb_wb  <= sb_mem;
                sb_mem <= sb_ex;
                if (redirect || hazard)
                    sb_ex <= '0;
                else
                    sb_ex <= '{v: i_id_valid && i_id_is_reg_write, rd: i_id_rd, ld: i_id_is_load};
            end
            if (o_stall_if || o_stall_id || o_stall_ex)
                o_stall_count <= o_stall_count + 1'b1;
            if (redirect)
                o_flush_count <= o_flush_count + 1'b1;
        end
    end

endmodule
